draw_menu_text: RTL and testbench
=================================

// Module: draw_menu_text
// PURPOSE
//  Text-overlay stage of the menu video pipeline. Converts the incoming VGA beam position into a
//  character cell address (char_xy) and glyph line (char_line) for the 16x16 character ROM and
//  the 8x16 font ROM, then overlays the returned glyph pixels onto the incoming RGB stream.
//  The selected menu row (e.g. 0 = "Single Player", 6 = "Multi Player") is drawn in a blinking
//  highlight colour. Sits between the background/rect drawing stage and the VGA output register.
// PARAMETERS
//  XPOS         448      left edge of the text box in pixels (box is 128 px wide: 16 cols x 8 px)
//  YPOS         200      top edge of the text box in lines (box is 256 lines: 16 rows x 16 lines)
//  TEXT_COLOR   12'hFFF  RGB444 colour of normal glyph pixels
//  SEL_COLOR    12'hF00  RGB444 colour of selected-row glyph pixels during the blink-on phase
//  BLINK_FRAMES 30       frames per blink phase; legal range 1..255
// PORTS
//  pclk             in   1   pixel clock; all state changes on rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  hcount_in        in   11  horizontal pixel position
//  vcount_in        in   11  vertical line position
//  hsync_in/vsync_in in  1   sync strobes, delayed unchanged to outputs
//  hblnk_in/vblnk_in in  1   blanking strobes, delayed unchanged to outputs
//  rgb_in           in   12  background colour
//  sel_en           in   1   1 = apply highlight to row sel_row
//  sel_row          in   4   selected character row (high nibble of char_xy)
//  char_xy          out  8   {row[3:0], col[3:0]} to character ROM (combinational ROM)
//  char_line        out  4   glyph line within the cell to font ROM
//  char_line_pixels in   8   glyph line from font ROM; bit 7 = leftmost pixel; 1-cycle ROM latency
//  hcount_out/vcount_out, hsync_out/vsync_out, hblnk_out/vblnk_out  out  11/11/1/1/1/1  delayed 3
//  rgb_out          out  12  composited colour
// BEHAVIOUR
//  Reset: every output, all pipeline registers, frame counter and previous-vsync register = 0;
//   blink_on = 1. Reset is honoured mid-frame; first valid output 3 cycles after rst_n rises.
//  Region: in_box = (hcount_in - XPOS) < 128 and (vcount_in - YPOS) < 256, unsigned 11-bit
//   subtraction (values below XPOS/YPOS wrap large and fall outside).
//  Stage 1 (edge 1): char_xy = {rel_y[7:4], rel_x[6:3]}, char_line = rel_y[3:0] when in_box,
//   else both 0. Also registers in_box, rel_x[2:0], row hit (sel_en && rel_y[7:4]==sel_row) and
//   all timing/rgb inputs.
//  Stage 2 (edge 2): font ROM returns char_line_pixels for stage-1 address; stage-1 data shifted.
//  Stage 3 (edge 3): pix = char_line_pixels[7 - rel_x[2:0]] (stage-2 copies). rgb_out =
//   (in_box && pix && !hblnk && !vblnk) ? colour : rgb; colour = SEL_COLOR if row hit and
//   blink_on, else TEXT_COLOR. Timing outputs = inputs delayed exactly 3 cycles.
//  Latency: fixed 3 pclk cycles, no stalls, one pixel per cycle.
//  Blink FSM (states BLINK_ON/BLINK_OFF = blink_on 1/0): vsync rising edge detected from vsync_in
//   vs. registered previous value. On each edge frame_cnt increments; when frame_cnt ==
//   BLINK_FRAMES-1 it wraps to 0 and blink_on toggles in the same cycle. No edge = hold.
//  sel_row/sel_en changes take effect on the pixel sampled in the same cycle (no frame alignment).
//  Blank pixels inside the box pass rgb_in through unchanged.
// TESTING
//  1) rst_n=0 mid-line -> all outputs 0 immediately; release -> timing outputs track inputs at +3.
//  2) hcount=XPOS+9, vcount=YPOS+0x65 -> char_xy=8'h61, char_line=4'h5 one cycle after.
//  3) Font model returns 8'b1000_0000 for every line, hcount=XPOS+8 -> rgb_out=12'hFFF;
//     hcount=XPOS+9 -> rgb_out=rgb_in; hcount=XPOS-1 and XPOS+128 -> rgb_out=rgb_in, char_xy=0.
//  4) sel_en=1, sel_row=6, glyph pixel on row 6 -> rgb_out=12'hF00; same on row 0 -> 12'hFFF.
//  5) BLINK_FRAMES=2: after 2 vsync rising edges row-6 pixel = 12'hFFF, after 4 -> 12'hF00.
//  6) hblnk_in=1 inside box with pixel set -> rgb_out=rgb_in; vsync held high -> no extra count.

Source files
------------

// File: rtl/draw_menu_text.sv
// Text overlay for the menu screen: beam position -> char ROM address, glyph pixel -> RGB overlay.
// Latency: fixed 3 pclk cycles on every output; char_xy/char_line are valid 1 cycle after the inputs.
// Backpressure: none; one pixel per cycle, the stage never stalls.
module draw_menu_text #(
  parameter logic [10:0] XPOS         = 11'd448,
  parameter logic [10:0] YPOS         = 11'd200,
  parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
  parameter logic [11:0] SEL_COLOR    = 12'hF00,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        sel_en,
  input  logic [3:0]  sel_row,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_line_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  typedef enum logic {BLINK_OFF = 1'b0, BLINK_ON = 1'b1} blink_t;

  blink_t      blink_state, blink_state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic        vsync_prev;

  // Position relative to the text box; below-origin values wrap large and fail the range test.
  logic [10:0] rel_x, rel_y;
  logic        in_box;

  // Stage 1 and stage 2 pipeline copies
  logic [10:0] hcount_1, vcount_1, hcount_2, vcount_2;
  logic        hsync_1, vsync_1, hblnk_1, vblnk_1;
  logic        hsync_2, vsync_2, hblnk_2, vblnk_2;
  logic [11:0] rgb_1, rgb_2;
  logic        in_box_1, in_box_2, hit_1, hit_2;
  logic [2:0]  relx_1, relx_2;

  logic        pix;
  logic [11:0] glyph_color;

  assign rel_x  = hcount_in - XPOS;
  assign rel_y  = vcount_in - YPOS;
  assign in_box = (rel_x < 11'd128) && (rel_y < 11'd256);

  // Stage 1: ROM address generation and capture of the pixel context
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy   <= '0;
      char_line <= '0;
      in_box_1  <= 1'b0;
      relx_1    <= '0;
      hit_1     <= 1'b0;
      hcount_1  <= '0;
      vcount_1  <= '0;
      hsync_1   <= 1'b0;
      vsync_1   <= 1'b0;
      hblnk_1   <= 1'b0;
      vblnk_1   <= 1'b0;
      rgb_1     <= '0;
    end else begin
      char_xy   <= in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
      char_line <= in_box ? rel_y[3:0] : 4'h0;
      in_box_1  <= in_box;
      relx_1    <= rel_x[2:0];
      hit_1     <= sel_en && (rel_y[7:4] == sel_row);
      hcount_1  <= hcount_in;
      vcount_1  <= vcount_in;
      hsync_1   <= hsync_in;
      vsync_1   <= vsync_in;
      hblnk_1   <= hblnk_in;
      vblnk_1   <= vblnk_in;
      rgb_1     <= rgb_in;
    end
  end

  // Stage 2: wait out the font ROM read latency
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_2 <= 1'b0;
      relx_2   <= '0;
      hit_2    <= 1'b0;
      hcount_2 <= '0;
      vcount_2 <= '0;
      hsync_2  <= 1'b0;
      vsync_2  <= 1'b0;
      hblnk_2  <= 1'b0;
      vblnk_2  <= 1'b0;
      rgb_2    <= '0;
    end else begin
      in_box_2 <= in_box_1;
      relx_2   <= relx_1;
      hit_2    <= hit_1;
      hcount_2 <= hcount_1;
      vcount_2 <= vcount_1;
      hsync_2  <= hsync_1;
      vsync_2  <= vsync_1;
      hblnk_2  <= hblnk_1;
      vblnk_2  <= vblnk_1;
      rgb_2    <= rgb_1;
    end
  end

  // Glyph bit 7 is the leftmost pixel of the cell
  assign pix         = char_line_pixels[3'd7 - relx_2];
  assign glyph_color = (hit_2 && (blink_state == BLINK_ON)) ? SEL_COLOR : TEXT_COLOR;

  // Stage 3: composite glyph over background and register the outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_2;
      vcount_out <= vcount_2;
      hsync_out  <= hsync_2;
      vsync_out  <= vsync_2;
      hblnk_out  <= hblnk_2;
      vblnk_out  <= vblnk_2;
      rgb_out    <= (in_box_2 && pix && !hblnk_2 && !vblnk_2) ? glyph_color : rgb_2;
    end
  end

  // Blink state, frame counter and vsync edge history
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_state <= BLINK_ON;
      frame_cnt   <= '0;
      vsync_prev  <= 1'b0;
    end else begin
      blink_state <= blink_state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      vsync_prev  <= vsync_in;
    end
  end

  // Count vsync rising edges; toggle the highlight phase when the count wraps
  always_comb begin
    blink_state_nxt = blink_state;
    frame_cnt_nxt   = frame_cnt;
    if (vsync_in && !vsync_prev) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt_nxt   = 8'd0;
        blink_state_nxt = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_nxt = frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_draw_menu_text.sv
// Directed bench for draw_menu_text with a registered constant-pattern font ROM model.
// Latency: checks outputs 3 cycles after inputs, char address 1 cycle after.
// Backpressure: none in the design; stimulus is one pixel per cycle.
module tb_draw_menu_text;

  localparam logic [10:0] XPOS = 11'd448;
  localparam logic [10:0] YPOS = 11'd200;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        sel_en;
  logic [3:0]  sel_row;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_line_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [7:0]  font_val;
  int          checks = 0;
  int          failures = 0;

  always #5 pclk = ~pclk;

  draw_menu_text #(.XPOS(XPOS), .YPOS(YPOS), .BLINK_FRAMES(2)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .sel_en(sel_en), .sel_row(sel_row),
    .char_xy(char_xy), .char_line(char_line),
    .char_line_pixels(char_line_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Font ROM model: one cycle of read latency, same pattern for every address
  always @(posedge pclk) char_line_pixels <= font_val;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Timing/rgb stimulus for the latency sweep; hcount stays left of the box
  function automatic logic [37:0] vec(input int k);
    logic [10:0] h, v;
    logic [11:0] c;
    h = 11'(k * 3);
    v = 11'(1000 - k);
    c = 12'(k * 291 + 5);
    return {h, v, k[0], k[1], k[2], k[3], c};
  endfunction

  task automatic drive_vec(input logic [37:0] x);
    {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in} = x;
  endtask

  function automatic logic [37:0] out_vec();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
  endfunction

  // Hold one pixel steady long enough to fill the pipeline
  task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    repeat (4) @(negedge pclk);
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    repeat (5) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (5) @(negedge pclk);
  endtask

  initial begin
    rst_n = 1'b0;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = '0; sel_en = 1'b0; sel_row = '0; font_val = 8'h80;
    repeat (2) @(negedge pclk);
    check("reset_timing", {10'd0, out_vec()}, 48'd0);
    check("reset_char", {36'd0, char_xy, char_line}, 48'd0);

    // Latency sweep: outputs equal inputs from three cycles earlier
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n >= 3) check($sformatf("latency_%0d", n), {10'd0, out_vec()}, {10'd0, vec(n - 3)});
      drive_vec(vec(n));
      @(negedge pclk);
    end

    // Reset mid-line clears outputs at once
    #1 rst_n = 1'b0;
    #1;
    check("midreset_timing", {10'd0, out_vec()}, 48'd0);
    @(negedge pclk);
    rst_n = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;

    // Character address appears one cycle after the beam position
    pixel(11'd10, 11'd10, 12'h123);
    check("outside_char_xy", {40'd0, char_xy}, 48'h00);
    hcount_in = XPOS + 11'd9;
    vcount_in = YPOS + 11'h65;
    @(negedge pclk);
    check("char_xy_1cyc", {40'd0, char_xy}, 48'h61);
    check("char_line_1cyc", {44'd0, char_line}, 48'h5);
    repeat (3) @(negedge pclk);
    check("col1_px1_clear", {36'd0, rgb_out}, {36'd0, rgb_in});

    // Glyph overlay at the box edges with leftmost-pixel pattern
    pixel(XPOS + 11'd8, YPOS + 11'h10, 12'h0A5);
    check("px0_set", {36'd0, rgb_out}, 48'hFFF);
    pixel(XPOS + 11'd0, YPOS + 11'd0, 12'h0A5);
    check("box_origin", {36'd0, rgb_out}, 48'hFFF);
    pixel(XPOS + 11'd9, YPOS + 11'h10, 12'h3C3);
    check("px1_clear", {36'd0, rgb_out}, 48'h3C3);
    pixel(XPOS - 11'd1, YPOS + 11'h10, 12'h456);
    check("left_out_rgb", {36'd0, rgb_out}, 48'h456);
    check("left_out_xy", {40'd0, char_xy}, 48'h00);
    pixel(XPOS + 11'd128, YPOS + 11'h10, 12'h789);
    check("right_out_rgb", {36'd0, rgb_out}, 48'h789);
    check("right_out_xy", {40'd0, char_xy}, 48'h00);
    pixel(XPOS + 11'd120, YPOS + 11'd255, 12'h111);
    check("bottom_in_rgb", {36'd0, rgb_out}, 48'hFFF);
    check("bottom_in_xy", {36'd0, char_xy, char_line}, 48'hFFF);
    pixel(XPOS + 11'd120, YPOS + 11'd256, 12'h222);
    check("bottom_out_rgb", {36'd0, rgb_out}, 48'h222);
    pixel(XPOS + 11'd8, YPOS - 11'd1, 12'h333);
    check("top_out_rgb", {36'd0, rgb_out}, 48'h333);

    // Rightmost-pixel pattern exercises the bit index
    font_val = 8'h01;
    pixel(XPOS + 11'd15, YPOS + 11'h20, 12'h444);
    check("px7_set", {36'd0, rgb_out}, 48'hFFF);
    pixel(XPOS + 11'd14, YPOS + 11'h20, 12'h444);
    check("px6_clear", {36'd0, rgb_out}, 48'h444);
    font_val = 8'h80;

    // Row highlight
    sel_en = 1'b1; sel_row = 4'd6;
    pixel(XPOS + 11'd8, YPOS + 11'h65, 12'h555);
    check("sel_row6", {36'd0, rgb_out}, 48'hF00);
    pixel(XPOS + 11'd8, YPOS + 11'h03, 12'h555);
    check("sel_row0_normal", {36'd0, rgb_out}, 48'hFFF);
    sel_en = 1'b0;
    pixel(XPOS + 11'd8, YPOS + 11'h65, 12'h555);
    check("sel_disabled", {36'd0, rgb_out}, 48'hFFF);
    sel_en = 1'b1;

    // Blanking suppresses the overlay
    hblnk_in = 1'b1;
    pixel(XPOS + 11'd8, YPOS + 11'h65, 12'h666);
    check("hblnk_pass", {36'd0, rgb_out}, 48'h666);
    hblnk_in = 1'b0; vblnk_in = 1'b1;
    pixel(XPOS + 11'd8, YPOS + 11'h65, 12'h667);
    check("vblnk_pass", {36'd0, rgb_out}, 48'h667);
    vblnk_in = 1'b0;

    // Blink phases with two frames per phase; long pulses count once each
    pixel(XPOS + 11'd8, YPOS + 11'h65, 12'h777);
    vsync_pulse();
    check("blink_1edge", {36'd0, rgb_out}, 48'hF00);
    vsync_pulse();
    check("blink_2edge", {36'd0, rgb_out}, 48'hFFF);
    vsync_pulse();
    check("blink_3edge", {36'd0, rgb_out}, 48'hFFF);
    vsync_pulse();
    check("blink_4edge", {36'd0, rgb_out}, 48'hF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
